ball_launcher: RTL

//  Ball source for the board: blue and red reservoirs at the top that emit ball pulses into the first cell chain.

---
 rtl/turingtumble_pkg.sv | 9 +
 rtl/ball_sync_edge.sv | 26 ++
 rtl/ball_launcher.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/turingtumble_pkg.sv
// rtl/turingtumble_pkg.sv - shared types and constants for the ball launcher
package turingtumble_pkg;

   typedef enum logic [1:0] {IDLE, RELEASE, FLIGHT, HALTED} launcher_state_t;
   typedef enum logic {BLUE, RED} ball_colour_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ball_sync_edge.sv
// rtl/ball_sync_edge.sv - 2-flop synchroniser with registered rising-edge detect
module ball_sync_edge
   import turingtumble_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

endmodule

// File: rtl/ball_launcher.sv
// rtl/ball_launcher.sv - ball reservoirs and game sequencer; LAUNCHER_WATCHDOG_EN adds an in-flight timeout
module ball_launcher
   import turingtumble_pkg::*;
#(
   parameter int N_BLUE    = 8,
   parameter int N_RED     = 8,
   parameter int CW        = 4,
   parameter int PULSE_LEN = 4,
   parameter int TIMEOUT   = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start_blue,
   input  logic          i_start_red,
   input  logic          i_trig_left,
   input  logic          i_trig_right,
   input  logic          i_intercept,
   output logic          o_ball_blue,
   output logic          o_ball_red,
   output logic [CW-1:0] o_blue_left,
   output logic [CW-1:0] o_red_left,
   output logic          o_busy,
   output logic          o_halted,
   output logic          o_error
);

   localparam int PW = $clog2(PULSE_LEN);

   logic start_blue, start_red, trig_left, trig_right, intercept;

   ball_sync_edge u_sync_start_blue (.clk(clk), .rst(rst), .async_in(i_start_blue), .rise(start_blue));
   ball_sync_edge u_sync_start_red  (.clk(clk), .rst(rst), .async_in(i_start_red),  .rise(start_red));
   ball_sync_edge u_sync_trig_left  (.clk(clk), .rst(rst), .async_in(i_trig_left),  .rise(trig_left));
   ball_sync_edge u_sync_trig_right (.clk(clk), .rst(rst), .async_in(i_trig_right), .rise(trig_right));
   ball_sync_edge u_sync_intercept  (.clk(clk), .rst(rst), .async_in(i_intercept),  .rise(intercept));

   launcher_state_t state, state_n;
   ball_colour_t    colour, colour_n;
   logic [PW-1:0]   pcnt;
   logic [CW-1:0]   blue_cnt, red_cnt;
   logic            pend, err;
   logic            blue_dec, red_dec, err_set, pend_set;
   logic            pulse_done, timeout;

   assign pulse_done = (pcnt == PW'(PULSE_LEN - 1));

`ifdef LAUNCHER_WATCHDOG_EN
   logic [15:0] wd;

   // Held at zero outside FLIGHT, so every entry into FLIGHT starts from 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 wd <= '0;
      else if (state != FLIGHT) wd <= '0;
      else                     wd <= wd + 16'd1;
   end

   assign timeout = (state == FLIGHT) && (wd == 16'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign timeout        = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      colour_n = colour;
      blue_dec = 1'b0;
      red_dec  = 1'b0;
      err_set  = 1'b0;
      pend_set = 1'b0;
      case (state)
         IDLE: begin
            if (start_blue) begin
               if (blue_cnt != '0) begin
                  state_n  = RELEASE;
                  colour_n = BLUE;
                  blue_dec = 1'b1;
               end else state_n = HALTED;
            end else if (start_red) begin
               if (red_cnt != '0) begin
                  state_n  = RELEASE;
                  colour_n = RED;
                  red_dec  = 1'b1;
               end else state_n = HALTED;
            end
         end
         RELEASE: begin
            if (intercept) pend_set = 1'b1;
            if (pulse_done) state_n = FLIGHT;
         end
         FLIGHT: begin
            if (intercept || pend) begin
               state_n = HALTED;
            end else if (trig_left && trig_right) begin
               state_n = HALTED;
               err_set = 1'b1;
            end else if (trig_left) begin
               if (blue_cnt != '0) begin
                  state_n  = RELEASE;
                  colour_n = BLUE;
                  blue_dec = 1'b1;
               end else state_n = HALTED;
            end else if (trig_right) begin
               if (red_cnt != '0) begin
                  state_n  = RELEASE;
                  colour_n = RED;
                  red_dec  = 1'b1;
               end else state_n = HALTED;
            end else if (timeout) begin
               state_n = HALTED;
               err_set = 1'b1;
            end
         end
         default: state_n = HALTED;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         colour   <= BLUE;
         pcnt     <= '0;
         pend     <= 1'b0;
         err      <= 1'b0;
         blue_cnt <= CW'(N_BLUE);
         red_cnt  <= CW'(N_RED);
      end else begin
         state  <= state_n;
         colour <= colour_n;
         pcnt   <= (state == RELEASE && state_n == RELEASE) ? pcnt + 1'b1 : '0;
         pend   <= pend | pend_set;
         err    <= err | err_set;
         if (blue_dec) blue_cnt <= blue_cnt - 1'b1;
         if (red_dec)  red_cnt  <= red_cnt - 1'b1;
      end
   end

   assign o_ball_blue = (state == RELEASE) && (colour == BLUE);
   assign o_ball_red  = (state == RELEASE) && (colour == RED);
   assign o_busy      = (state == RELEASE) || (state == FLIGHT);
   assign o_halted    = (state == HALTED);
   assign o_error     = err;
   assign o_blue_left = blue_cnt;
   assign o_red_left  = red_cnt;

endmodule
